// File: rtl/coeff_reduce_collector_if.sv
`default_nettype none
// ============================================================================
// Module      : coeff_reduce_collector_if
// Description : Bus between the adder-tree producer / polynomial consumer and
//               coeff_reduce_collector.
//                 inputs_ready_signal  producer -> collector, idata qualifier
//                 idata                producer -> collector, unreduced sum
//                 poly_ack             consumer -> collector, buffer taken
//                 coeffs               collector -> consumer, reduced buffer
//                 outputs_ready_signal collector -> consumer, buffer complete
//                 overflow             collector -> consumer, sticky drop flag
//               master = producer/consumer side, slave = collector side.
// Revision    : 1.0  initial release
// ============================================================================
interface coeff_reduce_collector_if #(
    parameter int IN_WIDTH = 23,
    parameter int Q_WIDTH  = 13,
    parameter int N_COEFFS = 128
);
    logic                                inputs_ready_signal;
    logic [IN_WIDTH-1:0]                 idata;
    logic                                poly_ack;
    logic [N_COEFFS-1:0][Q_WIDTH-1:0]    coeffs;
    logic                                outputs_ready_signal;
    logic                                overflow;

    modport master (
        output inputs_ready_signal,
        output idata,
        output poly_ack,
        input  coeffs,
        input  outputs_ready_signal,
        input  overflow
    );

    modport slave (
        input  inputs_ready_signal,
        input  idata,
        input  poly_ack,
        output coeffs,
        output outputs_ready_signal,
        output overflow
    );
endinterface
`default_nettype wire

// File: rtl/coeff_reduce_collector.sv
`default_nettype none
// ============================================================================
// Module      : coeff_reduce_collector
// Description : Reduces each unreduced coefficient sum modulo Q through a
//               3-stage Barrett pipeline and collects N_COEFFS results, in
//               arrival order, into a buffer that is presented to a consumer
//               until acknowledged.
// Ports       : clk  - clock, rising edge
//               rst  - asynchronous active-high reset
//               bus  - coeff_reduce_collector_if slave modport
//                      (inputs_ready_signal, idata, poly_ack in;
//                       coeffs, outputs_ready_signal, overflow out)
// Revision    : 1.0  initial release
// ============================================================================
module coeff_reduce_collector #(
    parameter int IN_WIDTH = 23,
    parameter int Q        = 7681,
    parameter int Q_WIDTH  = $clog2(Q),
    parameter int N_COEFFS = 128
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    coeff_reduce_collector_if.slave    bus
);

    // Barrett constant, derived from the parameters only
    localparam logic [IN_WIDTH-1:0] c_mu =
        IN_WIDTH'((64'd1 << IN_WIDTH) / 64'(Q));
    localparam logic [IN_WIDTH-1:0]  c_q_in = IN_WIDTH'(Q);
    localparam logic [Q_WIDTH+1:0]   c_q_r  = (Q_WIDTH+2)'(Q);
    localparam int                   IDX_W  = (N_COEFFS > 1) ? $clog2(N_COEFFS) : 1;
    localparam logic [IDX_W-1:0]     c_last_idx = IDX_W'(N_COEFFS - 1);

    localparam logic [0:0] c_collect = 1'b0;
    localparam logic [0:0] c_full    = 1'b1;

    // ------------------------------------------------------------------
    // Stage 1: capture x and the full-width product x*MU
    // ------------------------------------------------------------------
    logic [2*IN_WIDTH-1:0] w_p;
    logic                  r_s1_v;
    logic [IN_WIDTH-1:0]   r_s1_x;
    logic [2*IN_WIDTH-1:0] r_s1_p;

    assign w_p = {{IN_WIDTH{1'b0}}, bus.idata} * {{IN_WIDTH{1'b0}}, c_mu};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_v <= 1'b0;
            r_s1_x <= '0;
            r_s1_p <= '0;
        end else begin
            r_s1_v <= bus.inputs_ready_signal;
            r_s1_x <= bus.idata;
            r_s1_p <= w_p;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: r = x - floor(p / 2^IN_WIDTH) * Q
    // q_est*Q never exceeds x, so the subtraction fits IN_WIDTH bits and
    // the true remainder (< 3Q) lives entirely in the low Q_WIDTH+2 bits.
    // ------------------------------------------------------------------
    logic [IN_WIDTH-1:0] w_q_est;
    logic [IN_WIDTH-1:0] w_q_times;
    logic [IN_WIDTH-1:0] w_diff;
    logic                r_s2_v;
    logic [Q_WIDTH+1:0]  r_s2_r;

    assign w_q_est   = r_s1_p[2*IN_WIDTH-1:IN_WIDTH];
    assign w_q_times = w_q_est * c_q_in;
    assign w_diff    = r_s1_x - w_q_times;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_v <= 1'b0;
            r_s2_r <= '0;
        end else begin
            r_s2_v <= r_s1_v;
            r_s2_r <= w_diff[Q_WIDTH+1:0];
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: up to two conditional subtractions bring r into [0, Q)
    // ------------------------------------------------------------------
    logic [Q_WIDTH+1:0] w_r1;
    logic [Q_WIDTH+1:0] w_r2;
    logic               r_s3_v;
    logic [Q_WIDTH-1:0] r_s3_d;

    assign w_r1 = (r_s2_r >= c_q_r) ? (r_s2_r - c_q_r) : r_s2_r;
    assign w_r2 = (w_r1   >= c_q_r) ? (w_r1   - c_q_r) : w_r1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s3_v <= 1'b0;
            r_s3_d <= '0;
        end else begin
            r_s3_v <= r_s2_v;
            r_s3_d <= w_r2[Q_WIDTH-1:0];
        end
    end

    // Bits that are structurally zero or not needed by the reduction
    logic w_unused;
    assign w_unused = ^{r_s1_p[IN_WIDTH-1:0], w_diff[IN_WIDTH-1:Q_WIDTH+2], w_r2[Q_WIDTH+1:Q_WIDTH]};

    // ------------------------------------------------------------------
    // Collection state machine and output buffer
    // ------------------------------------------------------------------
    logic [0:0]                       r_state;
    logic [IDX_W-1:0]                 r_idx;
    logic                             r_overflow;
    logic [N_COEFFS-1:0][Q_WIDTH-1:0] r_coeffs;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_collect;
            r_idx      <= '0;
            r_overflow <= 1'b0;
            r_coeffs   <= '0;
        end else begin
            case (r_state)
                c_collect: begin
                    if (r_s3_v) begin
                        r_coeffs[r_idx] <= r_s3_d;
                        if (r_idx == c_last_idx) begin
                            r_idx   <= '0;
                            r_state <= c_full;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                c_full: begin
                    if (bus.poly_ack) begin
                        // Ack takes priority: a coincident result starts the
                        // next polynomial at slot 0 instead of being dropped.
                        r_state <= c_collect;
                        if (r_s3_v) begin
                            r_coeffs[0] <= r_s3_d;
                            r_idx       <= IDX_W'(1);
                        end
                    end else if (r_s3_v) begin
                        r_overflow <= 1'b1;
                    end
                end
                default: begin
                    r_state <= c_collect;
                    r_idx   <= '0;
                end
            endcase
        end
    end

    assign bus.coeffs               = r_coeffs;
    assign bus.outputs_ready_signal = (r_state == c_full);
    assign bus.overflow             = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_coeff_reduce_collector.sv
`default_nettype none
// ============================================================================
// Module      : tb_coeff_reduce_collector
// Description : Directed self-checking bench for coeff_reduce_collector.
//               Inputs are applied on falling edges and outputs are observed
//               on falling edges, away from the active rising edge.
// Revision    : 1.0  initial release
// ============================================================================
module tb_coeff_reduce_collector;

    localparam int IN_WIDTH = 23;
    localparam int Q        = 7681;
    localparam int Q_WIDTH  = 13;
    localparam int N_COEFFS = 128;

    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;

    coeff_reduce_collector_if #(
        .IN_WIDTH (IN_WIDTH),
        .Q_WIDTH  (Q_WIDTH),
        .N_COEFFS (N_COEFFS)
    ) bus ();

    coeff_reduce_collector #(
        .IN_WIDTH (IN_WIDTH),
        .Q        (Q),
        .Q_WIDTH  (Q_WIDTH),
        .N_COEFFS (N_COEFFS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs at the current falling edge, advance to the next
    task automatic step(input logic v, input logic [IN_WIDTH-1:0] d, input logic ack);
        bus.inputs_ready_signal = v;
        bus.idata               = d;
        bus.poly_ack            = ack;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, '0, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.inputs_ready_signal = 1'b0;
        bus.idata               = '0;
        bus.poly_ack            = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst = 1'b1;
        bus.inputs_ready_signal = 1'b0;
        bus.idata               = '0;
        bus.poly_ack            = 1'b0;
        @(negedge clk);

        // ---- Reset state ----
        do_reset();
        chk("rst_ready",     32'(bus.outputs_ready_signal), 0);
        chk("rst_overflow",  32'(bus.overflow), 0);
        chk("rst_coeff0",    32'(bus.coeffs[0]), 0);
        chk("rst_coeff127",  32'(bus.coeffs[127]), 0);

        // ---- Single input equal to Q reduces to 0 ----
        step(1'b1, 23'd7681, 1'b0);
        idle(3);
        chk("q_coeff0",   32'(bus.coeffs[0]), 0);
        chk("q_overflow", 32'(bus.overflow), 0);
        chk("q_ready",    32'(bus.outputs_ready_signal), 0);

        // ---- Boundary values, back to back ----
        do_reset();
        step(1'b1, 23'd7680, 1'b0);
        step(1'b1, 23'd7682, 1'b0);
        step(1'b1, 23'd8388607, 1'b0);
        step(1'b1, 23'd15362, 1'b0);
        chk("bnd_c0",      32'(bus.coeffs[0]), 7680);
        chk("bnd_c1_early", 32'(bus.coeffs[1]), 0);
        idle(1);
        chk("bnd_c1", 32'(bus.coeffs[1]), 1);
        chk("bnd_c2_early", 32'(bus.coeffs[2]), 0);
        idle(1);
        chk("bnd_c2", 32'(bus.coeffs[2]), 955);
        idle(1);
        chk("bnd_c3", 32'(bus.coeffs[3]), 0);
        chk("bnd_c4", 32'(bus.coeffs[4]), 0);

        // ---- Full polynomial, coeffs[i] = i ----
        do_reset();
        for (int i = 0; i < N_COEFFS; i++) step(1'b1, 23'(i * 7682), 1'b0);
        idle(2);
        chk("full_ready_early", 32'(bus.outputs_ready_signal), 0);
        idle(1);
        chk("full_ready", 32'(bus.outputs_ready_signal), 1);
        chk("full_c0",    32'(bus.coeffs[0]), 0);
        chk("full_c1",    32'(bus.coeffs[1]), 1);
        chk("full_c64",   32'(bus.coeffs[64]), 64);
        chk("full_c127",  32'(bus.coeffs[127]), 127);
        chk("full_ovf",   32'(bus.overflow), 0);

        // ---- Overflow while FULL, then ack ----
        step(1'b1, 23'd100, 1'b0);
        idle(3);
        chk("ovf_flag",  32'(bus.overflow), 1);
        chk("ovf_ready", 32'(bus.outputs_ready_signal), 1);
        chk("ovf_c0",    32'(bus.coeffs[0]), 0);
        step(1'b0, '0, 1'b1);
        chk("ack_ready",  32'(bus.outputs_ready_signal), 0);
        chk("ack_sticky", 32'(bus.overflow), 1);
        step(1'b1, 23'd42, 1'b0);
        idle(3);
        chk("ack_c0",  32'(bus.coeffs[0]), 42);
        chk("ack_c1",  32'(bus.coeffs[1]), 1);
        chk("ack_ovf", 32'(bus.overflow), 1);

        // ---- Ack coinciding with a result in FULL ----
        do_reset();
        for (int i = 0; i < N_COEFFS; i++) step(1'b1, 23'(i * 7682), 1'b0);
        step(1'b1, 23'd5, 1'b0);
        idle(2);
        chk("coin_ready_pre", 32'(bus.outputs_ready_signal), 1);
        step(1'b0, '0, 1'b1);
        chk("coin_c0",    32'(bus.coeffs[0]), 5);
        chk("coin_ready", 32'(bus.outputs_ready_signal), 0);
        chk("coin_ovf",   32'(bus.overflow), 0);
        step(1'b1, 23'd7, 1'b0);
        idle(3);
        chk("coin_c1",   32'(bus.coeffs[1]), 7);
        chk("coin_c0_k", 32'(bus.coeffs[0]), 5);
        chk("coin_c2",   32'(bus.coeffs[2]), 2);

        // ---- Asynchronous reset with entries in flight ----
        do_reset();
        for (int i = 0; i < 60; i++) step(1'b1, 23'(i), 1'b0);
        idle(1);
        chk("ar_c5_pre",  32'(bus.coeffs[5]), 5);
        chk("ar_c57_pre", 32'(bus.coeffs[57]), 57);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_c5",    32'(bus.coeffs[5]), 0);
        chk("ar_c57",   32'(bus.coeffs[57]), 0);
        chk("ar_ready", 32'(bus.outputs_ready_signal), 0);
        chk("ar_ovf",   32'(bus.overflow), 0);
        @(negedge clk);
        rst = 1'b0;
        idle(4);
        chk("ar_c58", 32'(bus.coeffs[58]), 0);
        chk("ar_c59", 32'(bus.coeffs[59]), 0);
        chk("ar_c0_idle", 32'(bus.coeffs[0]), 0);
        step(1'b1, 23'd33, 1'b0);
        idle(3);
        chk("ar_c0", 32'(bus.coeffs[0]), 33);
        chk("ar_c1", 32'(bus.coeffs[1]), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/coeff_reduce_collector.md
Name: coeff_reduce_collector

Overview:
- Sits directly downstream of the polynomial multiplier's adder tree and consumes one wide, unreduced coefficient sum per valid cycle.
- Reduces each sum modulo Q through a 3-stage pipelined Barrett reducer.
- Collects N_COEFFS reduced coefficients into an output buffer, in arrival order.
- Presents the completed polynomial with a level ready signal and holds it until the consumer acknowledges.

Parameters:
IN_WIDTH, 23, width of incoming sum (adder tree IDATA_WIDTH 16 + 7 stages)
Q, 7681, modulus; must satisfy 2 < Q < 2^IN_WIDTH
Q_WIDTH, $clog2(Q), width of one reduced coefficient
N_COEFFS, 128, coefficients per polynomial
MU, floor(2^IN_WIDTH / Q), Barrett constant (derived; do not override)

Ports:
clk  input  1  clock; all state on rising edge
rst  input  1  asynchronous, active-high reset
inputs_ready_signal  input  1  idata valid this cycle (single-cycle qualifier, no backpressure)
idata  input  IN_WIDTH  unsigned unreduced coefficient sum
poly_ack  input  1  consumer has taken the buffered polynomial
coeffs  output  [N_COEFFS-1:0][Q_WIDTH-1:0]  reduced coefficient buffer
outputs_ready_signal  output  1  buffer holds a complete polynomial
overflow  output  1  sticky: a reduced coefficient was dropped

Behaviour:
- Reset (async assert, rst high):
  - All pipeline data and valid bits = 0; coeffs = all 0.
  - Write index = 0; state = COLLECT; outputs_ready_signal = 0; overflow = 0.
  - Asserting rst mid-operation discards in-flight pipeline entries and any partial polynomial.
- Barrett pipeline. Valid travels with the data; inputs_ready_signal is sampled every cycle.
  - S1: register x = idata and p = x*MU (full 2*IN_WIDTH product).
  - S2: q_est = p >> IN_WIDTH; register r = x - q_est*Q. Guaranteed 0 <= r < 3Q; width Q_WIDTH+2.
  - S3: r' = r - Q if r >= Q; r'' = r' - Q if r' >= Q; result r'' < Q, truncated to Q_WIDTH.
  - Latency: sample at edge t, S3 result valid at edge t+3, written to coeffs on edge t+3.
  - Throughput: 1 per cycle.
- State machine:
  - COLLECT:
    - Each S3 valid writes coeffs[idx] and increments idx.
    - If the write lands at idx == N_COEFFS-1: idx -> 0, go to FULL, outputs_ready_signal = 1 from that edge.
  - FULL:
    - coeffs is held stable; outputs_ready_signal = 1.
    - poly_ack = 1 -> COLLECT; outputs_ready_signal = 0 after that edge. Buffer contents are not cleared.
    - S3 valid with poly_ack = 0 -> coefficient dropped; overflow set and held until rst. State and idx unchanged.
    - S3 valid with poly_ack = 1 in the same cycle -> ack wins. Go to COLLECT, write coeffs[0] = result, idx = 1, no overflow.
  - poly_ack in COLLECT is ignored.
- Back-to-back polynomials:
  - Valid inputs continuously -> polynomial k+1 starts writing the cycle after polynomial k fills.
  - The consumer must ack the same cycle FULL is entered or lose data (flagged by overflow).
- Arithmetic: all unsigned; no signed inputs; no saturation.

Test Plan:
- Reset then single input idata=7681 -> three edges later coeffs[0]=0, overflow=0, outputs_ready_signal=0.
- Inputs 7680, 7682, 8388607, 15362 on consecutive cycles -> coeffs[0..3] = 7680, 1, 955, 0, each written 3 edges after its input edge.
- 128 consecutive inputs idata=i*7681+i (i=0..127) -> coeffs[i]=i. outputs_ready_signal rises on the edge 3 cycles after the last input edge.
- FULL with no ack, one extra input -> overflow=1 (sticky), coeffs unchanged. Then poly_ack -> outputs_ready_signal=0 next cycle; the next input lands in coeffs[0].
- FULL with poly_ack asserted the same cycle an S3 valid (value 5) arrives -> coeffs[0]=5, state COLLECT, index 1, overflow stays 0.
- 60 inputs, then rst pulsed asynchronously between edges with 2 entries in flight -> outputs immediately 0. After release, no stale writes; the next input writes coeffs[0].
